// File: rtl/dram_cache_miss_handler.sv
`default_nettype none
// ============================================================================
// Module   : dram_cache_miss_handler
// Purpose  : Returns read-hit data and write acks, tracks read misses in an
//            MSHR file, fetches lines from backing memory and emits fills.
// Revision : 1.0 - initial release
// ============================================================================
module dram_cache_miss_handler #(
    parameter int ADDR_WIDTH = 64,
    parameter int ID_WIDTH   = 16,
    parameter int LINE_WIDTH = 72,
    parameter int MSHR_DEPTH = 4,
    parameter int MID_WIDTH  = $clog2(MSHR_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  res_valid_i,
    output logic                  res_ready_o,
    input  logic                  res_write_i,
    input  logic                  res_hit_i,
    input  logic [ID_WIDTH-1:0]   res_id_i,
    input  logic [ADDR_WIDTH-1:0] res_addr_i,
    input  logic [LINE_WIDTH-1:0] res_data_i,
    output logic [ID_WIDTH-1:0]   rid_o,
    output logic [LINE_WIDTH-1:0] rdata_o,
    output logic                  rvalid_o,
    input  logic                  rready_i,
    output logic [ID_WIDTH-1:0]   bid_o,
    output logic                  bvalid_o,
    input  logic                  bready_i,
    output logic [MID_WIDTH-1:0]  mem_arid_o,
    output logic [ADDR_WIDTH-1:0] mem_araddr_o,
    output logic                  mem_arvalid_o,
    input  logic                  mem_arready_i,
    input  logic [MID_WIDTH-1:0]  mem_rid_i,
    input  logic [LINE_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_rvalid_i,
    output logic                  mem_rready_o,
    output logic                  fill_valid_o,
    output logic [ADDR_WIDTH-1:0] fill_addr_o,
    output logic [LINE_WIDTH-1:0] fill_data_o,
    output logic                  err_o
);

    typedef enum logic [1:0] {
        ST_FREE    = 2'd0,
        ST_PEND_AR = 2'd1,
        ST_WAIT_R  = 2'd2
    } mshr_state_t;

    mshr_state_t           r_state [MSHR_DEPTH];
    logic [ID_WIDTH-1:0]   r_id    [MSHR_DEPTH];
    logic [ADDR_WIDTH-1:0] r_addr  [MSHR_DEPTH];

    logic                  r_rvalid;
    logic [ID_WIDTH-1:0]   r_rid;
    logic [LINE_WIDTH-1:0] r_rdata;
    logic                  r_bvalid;
    logic [ID_WIDTH-1:0]   r_bid;
    logic                  r_arvalid;
    logic [MID_WIDTH-1:0]  r_arid;
    logic [ADDR_WIDTH-1:0] r_araddr;
    logic                  r_fill_valid;
    logic [ADDR_WIDTH-1:0] r_fill_addr;
    logic [LINE_WIDTH-1:0] r_fill_data;
    logic                  r_err;

    logic                  w_free_any;
    logic [MID_WIDTH-1:0]  w_free_idx;
    logic                  w_pend_any;
    logic [MID_WIDTH-1:0]  w_pend_idx;
    logic                  w_rfree;
    logic                  w_bfree;
    logic                  w_mem_rready;
    logic                  w_mem_hs;
    logic                  w_ret_ok;
    logic                  w_res_ready;
    logic                  w_acc;
    logic                  w_acc_hit;
    logic                  w_acc_miss;
    logic                  w_acc_wr;
    logic                  w_ar_load;

    // Descending scan leaves the lowest matching index as the winner.
    always_comb begin
        w_free_any = 1'b0;
        w_free_idx = '0;
        w_pend_any = 1'b0;
        w_pend_idx = '0;
        for (int i = MSHR_DEPTH - 1; i >= 0; i--) begin
            if (r_state[i] == ST_FREE) begin
                w_free_any = 1'b1;
                w_free_idx = MID_WIDTH'(i);
            end
            if (r_state[i] == ST_PEND_AR) begin
                w_pend_any = 1'b1;
                w_pend_idx = MID_WIDTH'(i);
            end
        end
    end

    assign w_rfree      = !r_rvalid | rready_i;
    assign w_bfree      = !r_bvalid | bready_i;
    assign w_mem_rready = w_rfree & !rst;
    assign w_mem_hs     = mem_rvalid_i & w_mem_rready;
    assign w_ret_ok     = w_mem_hs & (r_state[mem_rid_i] == ST_WAIT_R);

    // A pending memory return owns the R slot, so read hits yield to it.
    always_comb begin
        w_res_ready = 1'b0;
        if (!rst) begin
            if (res_write_i)
                w_res_ready = w_bfree;
            else if (res_hit_i)
                w_res_ready = w_rfree & !mem_rvalid_i;
            else
                w_res_ready = w_free_any;
        end
    end

    assign w_acc      = res_valid_i & w_res_ready;
    assign w_acc_wr   = w_acc & res_write_i;
    assign w_acc_hit  = w_acc & !res_write_i & res_hit_i;
    assign w_acc_miss = w_acc & !res_write_i & !res_hit_i;
    assign w_ar_load  = (!r_arvalid | mem_arready_i) & w_pend_any;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MSHR_DEPTH; i++) begin
                r_state[i] <= ST_FREE;
                r_id[i]    <= '0;
                r_addr[i]  <= '0;
            end
            r_rvalid     <= 1'b0;
            r_rid        <= '0;
            r_rdata      <= '0;
            r_bvalid     <= 1'b0;
            r_bid        <= '0;
            r_arvalid    <= 1'b0;
            r_arid       <= '0;
            r_araddr     <= '0;
            r_fill_valid <= 1'b0;
            r_fill_addr  <= '0;
            r_fill_data  <= '0;
            r_err        <= 1'b0;
        end else begin
            // Allocation, AR issue and return act on entries in distinct states.
            if (w_acc_miss) begin
                r_state[w_free_idx] <= ST_PEND_AR;
                r_id[w_free_idx]    <= res_id_i;
                r_addr[w_free_idx]  <= res_addr_i;
            end

            if (w_ar_load) begin
                r_state[w_pend_idx] <= ST_WAIT_R;
                r_arvalid           <= 1'b1;
                r_arid              <= w_pend_idx;
                r_araddr            <= r_addr[w_pend_idx];
            end else if (mem_arready_i) begin
                r_arvalid <= 1'b0;
            end

            if (w_ret_ok)
                r_state[mem_rid_i] <= ST_FREE;

            if (w_mem_hs && !w_ret_ok)
                r_err <= 1'b1;

            if (w_ret_ok) begin
                r_rvalid <= 1'b1;
                r_rid    <= r_id[mem_rid_i];
                r_rdata  <= mem_rdata_i;
            end else if (w_acc_hit) begin
                r_rvalid <= 1'b1;
                r_rid    <= res_id_i;
                r_rdata  <= res_data_i;
            end else if (rready_i) begin
                r_rvalid <= 1'b0;
            end

            r_fill_valid <= w_ret_ok;
            if (w_ret_ok) begin
                r_fill_addr <= r_addr[mem_rid_i];
                r_fill_data <= mem_rdata_i;
            end

            if (w_acc_wr) begin
                r_bvalid <= 1'b1;
                r_bid    <= res_id_i;
            end else if (bready_i) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    assign res_ready_o   = w_res_ready;
    assign mem_rready_o  = w_mem_rready;
    assign rvalid_o      = r_rvalid;
    assign rid_o         = r_rid;
    assign rdata_o       = r_rdata;
    assign bvalid_o      = r_bvalid;
    assign bid_o         = r_bid;
    assign mem_arvalid_o = r_arvalid;
    assign mem_arid_o    = r_arid;
    assign mem_araddr_o  = r_araddr;
    assign fill_valid_o  = r_fill_valid;
    assign fill_addr_o   = r_fill_addr;
    assign fill_data_o   = r_fill_data;
    assign err_o         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dram_cache_miss_handler.sv
`default_nettype none
// ============================================================================
// Module   : tb_dram_cache_miss_handler
// Purpose  : Directed scenarios followed by randomized traffic scored against
//            response queues and an outstanding-miss table.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dram_cache_miss_handler;
    localparam int AW = 64;
    localparam int IW = 16;
    localparam int LW = 72;
    localparam int MD = 4;
    localparam int MW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          res_valid_i, res_ready_o, res_write_i, res_hit_i;
    logic [IW-1:0] res_id_i;
    logic [AW-1:0] res_addr_i;
    logic [LW-1:0] res_data_i;
    logic [IW-1:0] rid_o;
    logic [LW-1:0] rdata_o;
    logic          rvalid_o, rready_i;
    logic [IW-1:0] bid_o;
    logic          bvalid_o, bready_i;
    logic [MW-1:0] mem_arid_o;
    logic [AW-1:0] mem_araddr_o;
    logic          mem_arvalid_o, mem_arready_i;
    logic [MW-1:0] mem_rid_i;
    logic [LW-1:0] mem_rdata_i;
    logic          mem_rvalid_i, mem_rready_o;
    logic          fill_valid_o;
    logic [AW-1:0] fill_addr_o;
    logic [LW-1:0] fill_data_o;
    logic          err_o;

    always #5 clk = ~clk;

    dram_cache_miss_handler dut (
        .clk(clk), .rst(rst),
        .res_valid_i(res_valid_i), .res_ready_o(res_ready_o),
        .res_write_i(res_write_i), .res_hit_i(res_hit_i),
        .res_id_i(res_id_i), .res_addr_i(res_addr_i), .res_data_i(res_data_i),
        .rid_o(rid_o), .rdata_o(rdata_o), .rvalid_o(rvalid_o), .rready_i(rready_i),
        .bid_o(bid_o), .bvalid_o(bvalid_o), .bready_i(bready_i),
        .mem_arid_o(mem_arid_o), .mem_araddr_o(mem_araddr_o),
        .mem_arvalid_o(mem_arvalid_o), .mem_arready_i(mem_arready_i),
        .mem_rid_i(mem_rid_i), .mem_rdata_i(mem_rdata_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rready_o(mem_rready_o),
        .fill_valid_o(fill_valid_o), .fill_addr_o(fill_addr_o),
        .fill_data_o(fill_data_o), .err_o(err_o)
    );

    int tests = 0;
    int fails = 0;
    logic [MW-1:0] ar_log[$];

    // Reference state for the randomized phase
    logic [IW+LW-1:0] hitq[$];
    logic [IW+LW-1:0] retq[$];
    logic [IW-1:0]    bq[$];
    logic [IW+AW-1:0] unq[$];
    logic             fl_v    [MD];
    logic [IW-1:0]    fl_id   [MD];
    logic [AW-1:0]    fl_addr [MD];
    int               n_out;
    int               miss_cnt;
    int               kind;
    int               idx;
    int               start;
    logic             ex_fill;
    logic [AW-1:0]    ex_faddr;
    logic [LW-1:0]    ex_fdata;
    logic [LW-1:0]    d;
    logic             acc_res;
    logic             acc_ret;
    logic             gen;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        if (mem_arvalid_o && mem_arready_i) ar_log.push_back(mem_arid_o);
        @(negedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, 128'({res_ready_o, rvalid_o, bvalid_o, mem_arvalid_o,
                                 mem_rready_o, fill_valid_o, err_o}), 128'(0));
        chk({tag, "_dat"}, 128'(|{rid_o, rdata_o, bid_o, mem_arid_o, mem_araddr_o,
                                  fill_addr_o, fill_data_o}), 128'(0));
    endtask

    task automatic set_req(input logic wr, input logic hit, input logic [IW-1:0] id,
                           input logic [AW-1:0] addr, input logic [LW-1:0] data);
        res_valid_i = 1'b1;
        res_write_i = wr;
        res_hit_i   = hit;
        res_id_i    = id;
        res_addr_i  = addr;
        res_data_i  = data;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        res_valid_i = 1'b0; res_write_i = 1'b0; res_hit_i = 1'b0;
        res_id_i = '0; res_addr_i = '0; res_data_i = '0;
        rready_i = 1'b1; bready_i = 1'b1; mem_arready_i = 1'b1;
        mem_rvalid_i = 1'b0; mem_rid_i = '0; mem_rdata_i = '0;
        tick(); tick(); tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        // Read hit
        set_req(1'b0, 1'b1, 16'h12, 64'h0, 72'hAB_0000_0000_0000_1234);
        #1 chk("hit_ready", 128'(res_ready_o), 128'(1));
        tick();
        res_valid_i = 1'b0;
        chk("hit_rvalid", 128'(rvalid_o), 128'(1));
        chk("hit_rid", 128'(rid_o), 128'(16'h12));
        chk("hit_rdata", 128'(rdata_o), 128'(72'hAB_0000_0000_0000_1234));
        tick();
        chk("hit_one_cycle", 128'(rvalid_o), 128'(0));

        // Write with B backpressure
        bready_i = 1'b0;
        set_req(1'b1, 1'b0, 16'h7, 64'h40, 72'h0);
        #1 chk("wr_ready", 128'(res_ready_o), 128'(1));
        tick();
        res_id_i = 16'h8;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("wr_stall_ready", 128'(res_ready_o), 128'(0));
            chk("bvalid_hold", 128'(bvalid_o), 128'(1));
            chk("bid_hold", 128'(bid_o), 128'(16'h7));
            tick();
        end
        bready_i = 1'b1;
        #1 chk("wr_ready_again", 128'(res_ready_o), 128'(1));
        tick();
        res_valid_i = 1'b0;
        chk("bid_second", 128'({bvalid_o, bid_o}), 128'({1'b1, 16'h8}));
        tick();
        chk("bvalid_drop", 128'(bvalid_o), 128'(0));

        // Single read miss and return
        set_req(1'b0, 1'b0, 16'h5, 64'h1000, 72'h0);
        #1 chk("miss_ready", 128'(res_ready_o), 128'(1));
        tick();
        res_valid_i = 1'b0;
        chk("ar_not_early", 128'(mem_arvalid_o), 128'(0));
        tick();
        chk("ar_issue", 128'({mem_arvalid_o, mem_arid_o, mem_araddr_o}),
            128'({1'b1, 2'd0, 64'h1000}));
        tick();
        chk("ar_done", 128'(mem_arvalid_o), 128'(0));
        mem_rvalid_i = 1'b1; mem_rid_i = 2'd0; mem_rdata_i = 72'h55;
        #1 chk("mem_rready", 128'(mem_rready_o), 128'(1));
        tick();
        mem_rvalid_i = 1'b0;
        chk("ret_r", 128'({rvalid_o, rid_o, rdata_o}), 128'({1'b1, 16'h5, 72'h55}));
        chk("ret_fill", 128'({fill_valid_o, fill_addr_o, fill_data_o}),
            128'({1'b1, 64'h1000, 72'h55}));
        tick();
        chk("fill_pulse_end", 128'({fill_valid_o, rvalid_o}), 128'(0));

        // MSHR full: five misses, four entries
        ar_log.delete();
        for (int i = 0; i < 4; i++) begin
            set_req(1'b0, 1'b0, 16'(16'h20 + i), 64'h2000 + 64'(i) * 64'h40, 72'h0);
            #1 chk("fill_mshr_ready", 128'(res_ready_o), 128'(1));
            tick();
        end
        set_req(1'b0, 1'b0, 16'h24, 64'h2100, 72'h0);
        for (int k = 0; k < 5; k++) begin
            #1 chk("mshr_full_stall", 128'(res_ready_o), 128'(0));
            tick();
        end
        chk("ar_count", 128'(ar_log.size()), 128'(4));
        for (int i = 0; i < 4 && i < ar_log.size(); i++)
            chk("ar_order", 128'(ar_log[i]), 128'(i));
        mem_rvalid_i = 1'b1; mem_rid_i = 2'd2; mem_rdata_i = 72'h8_0000_0000_0000_0022;
        #1 chk("full_same_cycle", 128'(res_ready_o), 128'(0));
        tick();
        mem_rvalid_i = 1'b0;
        #1 chk("freed_ready", 128'(res_ready_o), 128'(1));
        chk("ret2_r", 128'({rid_o, rdata_o}), 128'({16'h22, 72'h8_0000_0000_0000_0022}));
        chk("ret2_fill", 128'({fill_valid_o, fill_addr_o}), 128'({1'b1, 64'h2080}));
        tick();
        res_valid_i = 1'b0;
        tick();
        chk("realloc_ar", 128'({mem_arvalid_o, mem_arid_o, mem_araddr_o}),
            128'({1'b1, 2'd2, 64'h2100}));

        // Reset mid-operation discards everything
        rst = 1'b1;
        tick();
        chk_all_zero("mid_reset");
        rst = 1'b0;
        tick(); tick();
        chk("rst_discards_ar", 128'(mem_arvalid_o), 128'(0));

        // Return and hit contend for R
        set_req(1'b0, 1'b0, 16'h9, 64'h3000, 72'h0);
        tick();
        res_valid_i = 1'b0;
        tick(); tick();
        mem_rvalid_i = 1'b1; mem_rid_i = 2'd0; mem_rdata_i = 72'h8_0000_0000_0000_0077;
        set_req(1'b0, 1'b1, 16'h33, 64'h0, 72'h99);
        #1;
        chk("hit_blocked", 128'(res_ready_o), 128'(0));
        chk("ret_wins", 128'(mem_rready_o), 128'(1));
        tick();
        mem_rvalid_i = 1'b0;
        chk("order_ret", 128'({rvalid_o, rid_o, rdata_o}),
            128'({1'b1, 16'h9, 72'h8_0000_0000_0000_0077}));
        #1 chk("hit_unblocked", 128'(res_ready_o), 128'(1));
        tick();
        res_valid_i = 1'b0;
        chk("order_hit", 128'({rvalid_o, rid_o, rdata_o}), 128'({1'b1, 16'h33, 72'h99}));
        tick();

        // Return for a FREE entry
        mem_rvalid_i = 1'b1; mem_rid_i = 2'd3; mem_rdata_i = 72'hEE;
        tick();
        mem_rvalid_i = 1'b0;
        chk("err_set", 128'({err_o, rvalid_o, fill_valid_o}), 128'({1'b1, 1'b0, 1'b0}));
        tick();
        chk("err_sticky", 128'(err_o), 128'(1));
        rst = 1'b1;
        tick();
        chk_all_zero("err_reset");
        rst = 1'b0;
        tick();

        // Randomized traffic
        n_out = 0; miss_cnt = 0; ex_fill = 1'b0; ex_faddr = '0; ex_fdata = '0;
        for (int m = 0; m < MD; m++) begin
            fl_v[m] = 1'b0; fl_id[m] = '0; fl_addr[m] = '0;
        end
        for (int cyc = 0; cyc < 5000; cyc++) begin
            gen = (cyc < 1500);
            if (!gen && !res_valid_i && !mem_rvalid_i && n_out == 0 &&
                hitq.size() == 0 && retq.size() == 0 && bq.size() == 0)
                break;
            chk("rnd_fill_valid", 128'(fill_valid_o), 128'(ex_fill));
            if (ex_fill)
                chk("rnd_fill_line", 128'({fill_addr_o, fill_data_o}),
                    128'({ex_faddr, ex_fdata}));
            rready_i      = ($urandom_range(3) != 0);
            bready_i      = ($urandom_range(3) != 0);
            mem_arready_i = ($urandom_range(2) != 0);
            if (gen && !res_valid_i && $urandom_range(3) != 0) begin
                kind = $urandom_range(2);
                d = {8'($urandom), 32'($urandom), 32'($urandom)};
                d[LW-1] = 1'b0;
                set_req(kind == 2, (kind == 0) ? 1'b1 : ((kind == 1) ? 1'b0 : 1'($urandom)),
                        16'($urandom),
                        (kind == 1) ? 64'h1_0000_0000 + 64'(miss_cnt) * 64'h40 : 64'($urandom),
                        d);
                if (kind == 1) miss_cnt++;
            end
            if (!mem_rvalid_i && $urandom_range(2) == 0) begin
                start = $urandom_range(MD - 1);
                for (int j = 0; j < MD; j++) begin
                    if (!mem_rvalid_i && fl_v[(start + j) % MD]) begin
                        d = {8'($urandom), 32'($urandom), 32'($urandom)};
                        d[LW-1] = 1'b1;
                        mem_rvalid_i = 1'b1;
                        mem_rid_i    = MW'((start + j) % MD);
                        mem_rdata_i  = d;
                    end
                end
            end
            #1;
            if (res_valid_i && !res_write_i && !res_hit_i)
                chk("rnd_miss_ready", 128'(res_ready_o), 128'(n_out < MD));
            if (rvalid_o && rready_i) begin
                if (rdata_o[LW-1]) begin
                    if (retq.size() == 0) chk("rnd_r_unexpected_ret", 128'(1), 128'(0));
                    else chk("rnd_r_return", 128'({rid_o, rdata_o}), 128'(retq.pop_front()));
                end else begin
                    if (hitq.size() == 0) chk("rnd_r_unexpected_hit", 128'(1), 128'(0));
                    else chk("rnd_r_hit", 128'({rid_o, rdata_o}), 128'(hitq.pop_front()));
                end
            end
            if (bvalid_o && bready_i) begin
                if (bq.size() == 0) chk("rnd_b_unexpected", 128'(1), 128'(0));
                else chk("rnd_bid", 128'(bid_o), 128'(bq.pop_front()));
            end
            if (mem_arvalid_o && mem_arready_i) begin
                chk("rnd_ar_mid_free", 128'(fl_v[mem_arid_o]), 128'(0));
                idx = -1;
                foreach (unq[j]) if (unq[j][AW-1:0] == mem_araddr_o) idx = j;
                chk("rnd_ar_addr_known", 128'(idx >= 0), 128'(1));
                if (idx >= 0) begin
                    fl_v[mem_arid_o]    = 1'b1;
                    fl_id[mem_arid_o]   = unq[idx][IW+AW-1:AW];
                    fl_addr[mem_arid_o] = unq[idx][AW-1:0];
                    unq.delete(idx);
                end
            end
            ex_fill = 1'b0;
            acc_ret = mem_rvalid_i && mem_rready_o;
            if (acc_ret) begin
                retq.push_back({fl_id[mem_rid_i], mem_rdata_i});
                ex_fill  = 1'b1;
                ex_faddr = fl_addr[mem_rid_i];
                ex_fdata = mem_rdata_i;
                fl_v[mem_rid_i] = 1'b0;
                n_out--;
            end
            acc_res = res_valid_i && res_ready_o;
            if (acc_res) begin
                if (res_write_i) bq.push_back(res_id_i);
                else if (res_hit_i) hitq.push_back({res_id_i, res_data_i});
                else begin
                    unq.push_back({res_id_i, res_addr_i});
                    n_out++;
                end
            end
            tick();
            if (acc_res) res_valid_i = 1'b0;
            if (acc_ret) mem_rvalid_i = 1'b0;
        end
        chk("rnd_drained", 128'(hitq.size() + retq.size() + bq.size() + unq.size() + n_out),
            128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
